// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: sole owner of the register-file write port. The WB stage wins by default;
// long-latency results wait in a FIFO, and a starvation counter forces a one-cycle FIFO drain.
// Optional macro WB_ARB_BYPASS_EN: an lu result skips the empty FIFO when WB is idle.
module wb_write_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3,
   parameter int ADDR_W       = 5
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_pipe_wen,
   input  logic [ADDR_W-1:0]           i_pipe_waddr,
   input  logic [31:0]                 i_pipe_wdata,
   output logic                        o_pipe_stall,
   input  logic                        i_lu_valid,
   input  logic [ADDR_W-1:0]           i_lu_waddr,
   input  logic [31:0]                 i_lu_wdata,
   output logic                        o_lu_ready,
   output logic                        o_rf_wen,
   output logic [ADDR_W-1:0]           o_rf_waddr,
   output logic [31:0]                 o_rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {
      PIPE_PRI    = 1'b0,
      FORCE_DRAIN = 1'b1
   } state_t;

   state_t             r_state;
   logic [STV_W-1:0]   r_starve;
   logic               r_rf_wen;
   logic [ADDR_W-1:0]  r_rf_waddr;
   logic [31:0]        r_rf_wdata;

   logic [ADDR_W-1:0]  r_mem_addr [FIFO_DEPTH];
   logic [31:0]        r_mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_empty;
   logic               w_lu_xfer;
   logic               w_push;
   logic               w_pop;
   logic               w_grant_pipe;
   logic               w_bypass;
   logic               w_grant;
   logic [STV_W-1:0]   w_starve_inc;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [31:0]        w_sel_data;

   assign w_empty      = (r_count == '0);
   assign o_lu_ready   = (r_count != CNT_W'(FIFO_DEPTH));
   assign w_lu_xfer    = i_lu_valid & o_lu_ready;
   assign o_pipe_stall = (r_state == FORCE_DRAIN) & i_pipe_wen;
   assign w_push       = w_lu_xfer & ~w_bypass;
   assign w_grant      = w_grant_pipe | w_pop | w_bypass;
   assign w_starve_inc = r_starve + STV_W'(1);

   assign o_rf_wen     = r_rf_wen;
   assign o_rf_waddr   = r_rf_waddr;
   assign o_rf_wdata   = r_rf_wdata;
   assign o_fifo_count = r_count;

   // Grant decision: a forced drain beats WB, WB beats a normal pop, bypass only when all idle
   always_comb begin
      w_grant_pipe = 1'b0;
      w_pop        = 1'b0;
      w_bypass     = 1'b0;
      if (r_state == FORCE_DRAIN) begin
         w_pop = 1'b1;
      end else if (i_pipe_wen) begin
         w_grant_pipe = 1'b1;
      end else if (!w_empty) begin
         w_pop = 1'b1;
      end
`ifdef WB_ARB_BYPASS_EN
      else if (w_lu_xfer) begin
         w_bypass = 1'b1;
      end
`endif
   end

   // Write-port source mux: WB result, bypassed lu result, or FIFO head
   always_comb begin
      w_sel_addr = r_mem_addr[r_rptr];
      w_sel_data = r_mem_data[r_rptr];
      if (w_grant_pipe) begin
         w_sel_addr = i_pipe_waddr;
         w_sel_data = i_pipe_wdata;
      end else if (w_bypass) begin
         w_sel_addr = i_lu_waddr;
         w_sel_data = i_lu_wdata;
      end
   end

   // Arbitration FSM with starvation tracking and the registered write port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= PIPE_PRI;
         r_starve   <= '0;
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         // r0 is read-only: the result is consumed but the write is suppressed
         r_rf_wen <= w_grant & (w_sel_addr != '0);
         if (w_grant) begin
            r_rf_waddr <= w_sel_addr;
            r_rf_wdata <= w_sel_data;
         end
         case (r_state)
            PIPE_PRI: begin
               if (w_pop) begin
                  r_starve <= '0;
               end else if (w_grant_pipe && !w_empty) begin
                  // FIFO is still non-empty next cycle because nothing was popped now
                  r_starve <= w_starve_inc;
                  if (w_starve_inc == STV_W'(STARVE_LIMIT)) begin
                     r_state <= FORCE_DRAIN;
                  end
               end
            end
            FORCE_DRAIN: begin
               r_starve <= '0;
               r_state  <= PIPE_PRI;
            end
            default: begin
               r_starve <= '0;
               r_state  <= PIPE_PRI;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; a full FIFO refuses pushes even while popping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until the pointers say otherwise
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_addr[r_wptr] <= i_lu_waddr;
         r_mem_data[r_wptr] <= i_lu_wdata;
      end
   end

endmodule
